// File: rtl/oam_dma_arbiter_pkg.sv
// oam_dma_arbiter_pkg: shared OAM DMA types and constants (package gb_pkg).
// Optional macro DMA_BUS_LOCK_EN is consumed by oam_dma_arbiter.
package gb_pkg;
    typedef enum logic [1:0] {DmaIdle, DmaStart, DmaXfer} dma_state_e;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [7:0] HI_PAGE = 8'hFF;
    localparam int DMA_LEN = 160;
    // Echo RAM pages E0-FF alias C0-DF.
    function automatic logic [7:0] src_eff(input logic [7:0] s);
        return s < 8'hE0 ? s : s & 8'hDF;
    endfunction
endpackage

// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if: CPU, main-bus, high-page and OAM signals of the DMA arbiter.
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  hi_addr;
    logic        hi_enable;
    logic        hi_write;
    logic [7:0]  hi_rdata;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    modport slave (
        input  cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
        output cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
               hi_addr, hi_enable, hi_write, oam_addr, oam_write, oam_wdata, dma_active
    );
    modport master (
        output cpu_addr, cpu_enable, cpu_write, cpu_wdata, bus_rdata, hi_rdata,
        input  cpu_rdata, bus_addr, bus_enable, bus_write, bus_wdata,
               hi_addr, hi_enable, hi_write, oam_addr, oam_write, oam_wdata, dma_active
    );
endinterface

// File: rtl/oam_dma_arbiter_engine.sv
// oam_dma_engine: OAM DMA FSM, source/pending-source registers, byte index and OAM strobe.
module oam_dma_engine
    import gb_pkg::*;
#(
    parameter int LEN = DMA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_end,
    input  logic        reg_wr,
    input  logic        stall,
    input  logic [7:0]  wdata,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] dma_addr,
    output logic [7:0]  src_next,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write,
    output logic        dma_active
);
    dma_state_e state, state_n;
    logic [7:0] src, src_n, src_next_n, idx, idx_n;
    logic       pend, pend_n, step, last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DmaIdle;
            src      <= '0;
            src_next <= '0;
            idx      <= '0;
            pend     <= 1'b0;
        end else begin
            state    <= state_n;
            src      <= src_n;
            src_next <= src_next_n;
            idx      <= idx_n;
            pend     <= pend_n;
        end
    end

    assign step = state == DmaXfer && m_end && !stall;
    assign last = idx == 8'(LEN - 1);

    // A restart write only takes effect after the following byte has been copied.
    always_comb begin
        state_n    = state;
        src_n      = src;
        src_next_n = reg_wr ? wdata : src_next;
        idx_n      = idx;
        pend_n     = pend;
        if (state != DmaXfer) begin
            if (reg_wr) begin
                state_n = DmaStart;
                src_n   = wdata;
            end else if (state == DmaStart && m_end) begin
                state_n = DmaXfer;
                idx_n   = '0;
            end
        end else begin
            if (reg_wr)
                pend_n = 1'b1;
            if (step && pend) begin
                src_n  = src_next_n;
                idx_n  = '0;
                pend_n = 1'b0;
            end else if (step && last) begin
                state_n = reg_wr ? DmaStart : DmaIdle;
                src_n   = reg_wr ? wdata : src;
                idx_n   = '0;
                pend_n  = 1'b0;
            end else if (step) begin
                idx_n = idx + 8'd1;
            end
        end
    end

    assign dma_active = state == DmaXfer;
    assign dma_addr   = {src_eff(src), idx};
    assign oam_write  = step && !reset;
    assign oam_addr   = idx;
    assign oam_wdata  = oam_write ? bus_rdata : '0;
endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: FF46 OAM DMA register and CPU/DMA main-bus sharing.
// Define DMA_BUS_LOCK_EN to block CPU main-bus access during a transfer; otherwise the CPU has priority.
module oam_dma_arbiter
    import gb_pkg::*;
#(
    parameter int          LEN      = DMA_LEN,
    parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
    input logic             clk,
    input logic             reset,
    oam_dma_arbiter_if.slave io
);
    logic [1:0]  tc;
    logic [15:0] dma_addr;
    logic [7:0]  src_next;
    logic        m_end, is_reg, is_hi, cpu_main, reg_wr, stall, dma_own, cpu_bus;

    always_ff @(posedge clk) begin
        if (reset)
            tc <= '0;
        else
            tc <= tc + 2'd1;
    end

    assign m_end    = tc == 2'd3;
    assign is_reg   = io.cpu_addr == REG_ADDR;
    assign is_hi    = io.cpu_addr[15:8] == HI_PAGE && !is_reg;
    assign cpu_main = io.cpu_enable && io.cpu_addr[15:8] != HI_PAGE;
    assign reg_wr   = io.cpu_enable && io.cpu_write && is_reg && m_end;
`ifdef DMA_BUS_LOCK_EN
    assign stall = 1'b0;
`else
    assign stall = cpu_main;
`endif

    oam_dma_engine #(.LEN(LEN)) engine (
        .clk       (clk),
        .reset     (reset),
        .m_end     (m_end),
        .reg_wr    (reg_wr),
        .stall     (stall),
        .wdata     (io.cpu_wdata),
        .bus_rdata (io.bus_rdata),
        .dma_addr  (dma_addr),
        .src_next  (src_next),
        .oam_addr  (io.oam_addr),
        .oam_wdata (io.oam_wdata),
        .oam_write (io.oam_write),
        .dma_active(io.dma_active)
    );

    // When the DMA owns the bus, CPU main-bus writes are dropped and reads see open bus.
    assign dma_own       = io.dma_active && !stall;
    assign cpu_bus       = cpu_main && !dma_own;
    assign io.bus_addr   = dma_own ? dma_addr : cpu_bus ? io.cpu_addr : '0;
    assign io.bus_enable = dma_own || cpu_bus;
    assign io.bus_write  = cpu_bus && io.cpu_write;
    assign io.bus_wdata  = io.bus_write ? io.cpu_wdata : '0;
    assign io.hi_enable  = io.cpu_enable && is_hi;
    assign io.hi_addr    = io.hi_enable ? io.cpu_addr[7:0] : '0;
    assign io.hi_write   = io.hi_enable && io.cpu_write;
    assign io.cpu_rdata  = is_reg ? src_next : is_hi ? io.hi_rdata : dma_own ? 8'hFF : io.bus_rdata;
endmodule
